// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video types: scheduler states and pixel-clock divider limits
package video_pkg;

  localparam int CE_DIV_MIN = 1;
  localparam int CE_DIV_MAX = 16;
  localparam int CE_CNT_W   = 4;

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    REQ       = 2'd1,
    WAIT_SWAP = 2'd2
  } sched_state_t;

endpackage

// File: rtl/ce_divider.sv
// rtl/ce_divider.sv - pixel-clock-enable divider, one ce pulse every CE_DIV clk_rgb cycles while run
module ce_divider
  import video_pkg::*;
#(
  parameter int CE_DIV = 2
) (
  input  logic clk_rgb,
  input  logic rst,
  input  logic run,
  output logic ce
);

  // out-of-range settings are clamped to the legal divider range
  localparam int DIV = (CE_DIV < CE_DIV_MIN) ? CE_DIV_MIN :
                       (CE_DIV > CE_DIV_MAX) ? CE_DIV_MAX : CE_DIV;
  localparam logic [CE_CNT_W-1:0] LAST = CE_CNT_W'(DIV - 1);

  logic [CE_CNT_W-1:0] cnt;

  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      cnt <= '0;
      ce  <= 1'b0;
    end else if (run) begin
      ce  <= (cnt == LAST);
      cnt <= (cnt == LAST) ? '0 : cnt + CE_CNT_W'(1);
    end else begin
      ce  <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - frame update handshake between vsync, game logic and renderer swap
module frame_scheduler
  import video_pkg::*;
#(
  parameter int CE_DIV      = 2,
  parameter int MISS_WIDTH  = 8,
  parameter int FRAME_WIDTH = 16
) (
  input  logic                   clk_rgb,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   vs,
  output logic                   ce,
  output logic                   update_req,
  input  logic                   update_ack,
  output logic                   swap,
  output logic [MISS_WIDTH-1:0]  missed_frames,
  output logic [FRAME_WIDTH-1:0] frame_count
);

  sched_state_t state, state_next;
  logic vs_q, vs_rise, vs_fall;
  logic swap_next, miss_inc;

  ce_divider #(.CE_DIV(CE_DIV)) u_ce_divider (
    .clk_rgb (clk_rgb),
    .rst     (rst),
    .run     (run),
    .ce      (ce)
  );

  assign vs_rise = vs & ~vs_q;
  assign vs_fall = ~vs & vs_q;

  always_comb begin
    state_next = state;
    swap_next  = 1'b0;
    miss_inc   = 1'b0;
    unique case (state)
      SCAN: begin
        if (vs_rise) state_next = REQ;
      end
      REQ: begin
        // an ack always beats a coincident new sync interval
        if (update_ack) begin
          if (vs_fall) begin
            swap_next  = 1'b1;
            state_next = SCAN;
          end else begin
            state_next = WAIT_SWAP;
          end
        end else if (vs_rise) begin
          miss_inc = 1'b1;
        end
      end
      WAIT_SWAP: begin
        if (vs_fall) begin
          swap_next  = 1'b1;
          state_next = SCAN;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      state         <= SCAN;
      vs_q          <= 1'b0;
      update_req    <= 1'b0;
      swap          <= 1'b0;
      missed_frames <= '0;
      frame_count   <= '0;
    end else begin
      state      <= state_next;
      vs_q       <= vs;
      update_req <= (state_next == REQ);
      swap       <= swap_next;
      if (miss_inc && (missed_frames != '1))
        missed_frames <= missed_frames + MISS_WIDTH'(1);
      if (vs_rise)
        frame_count <= frame_count + FRAME_WIDTH'(1);
    end
  end

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter CE_DIV, default 2: clk_rgb cycles per pixel-clock-enable pulse, legal range 1..16.
REQ-002 Parameter MISS_WIDTH, default 8: width of the missed-frame counter.
REQ-003 Parameter FRAME_WIDTH, default 16: width of the frame counter.
REQ-004 clk_rgb  input  1  single clock; all logic is posedge clk_rgb.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 run  input  1  enables pixel-clock-enable generation; low freezes the scan.
REQ-007 vs  input  1  vertical sync from the pixel iterator, high during the sync interval.
REQ-008 ce  output  1  pixel-clock enable to the pixel iterator.
REQ-009 update_req  output  1  request to game logic to compute the next frame.
REQ-010 update_ack  input  1  game logic has finished the frame; sampled only while update_req is high.
REQ-011 swap  output  1  one-cycle pulse that commits the new frame to the renderer.
REQ-012 missed_frames  output  MISS_WIDTH  saturating count of sync intervals that began while a request was outstanding.
REQ-013 frame_count  output  FRAME_WIDTH  wrapping count of vs rising edges.

Function
REQ-014 A divider counter runs 0..CE_DIV-1 while run=1; ce=1 exactly in cycles where the counter equals CE_DIV-1; the counter then returns to 0.
REQ-015 With CE_DIV=1 and run=1, ce is high every cycle.
REQ-016 While run=0, the divider holds its value, ce=0, and the divider resumes from the held value when run returns to 1.
REQ-017 vs is registered once (vs_q); vs_rise = vs & ~vs_q and vs_fall = ~vs & vs_q, evaluated every clk_rgb cycle regardless of ce.
REQ-018 frame_count increments by 1 on each vs_rise and wraps from all-ones to 0.
REQ-019 FSM states: SCAN, REQ, WAIT_SWAP.
REQ-020 SCAN + vs_rise -> REQ; update_req goes high in the following cycle.
REQ-021 REQ: update_req=1; update_ack=1 -> WAIT_SWAP, and update_req=0 from the next cycle.
REQ-022 REQ + update_ack=1 + vs_fall in the same cycle -> swap=1 in the next cycle, then SCAN (WAIT_SWAP is skipped).
REQ-023 REQ + vs_rise without update_ack -> missed_frames+1 (saturating at all-ones); the FSM stays in REQ.
REQ-024 REQ + vs_rise + update_ack in the same cycle -> ack wins: go to WAIT_SWAP, no miss counted.
REQ-025 WAIT_SWAP + vs_fall -> swap=1 for exactly one cycle, then SCAN.
REQ-026 WAIT_SWAP + vs_rise -> no miss counted; keep waiting for vs_fall.
REQ-027 update_ack outside REQ is ignored.
REQ-028 All outputs are registered; swap is never high for two consecutive cycles.

Reset
REQ-029 On rst=1 at a clock edge: divider=0, ce=0, vs_q=0, state=SCAN, update_req=0, swap=0, missed_frames=0, frame_count=0.
REQ-030 rst takes priority over run, vs and update_ack; reset mid-request drops update_req in the next cycle with no swap.
REQ-031 The first ce after rst deasserts with run=1 occurs CE_DIV cycles later.

Structure
REQ-032 The FSM state enum (SCAN, REQ, WAIT_SWAP) and the CE_DIV range limits reside in the shared video package.
REQ-033 The divider is one sub-module, ce_divider (ports clk_rgb, rst, run, ce), reusable by other video blocks; the FSM and counters live in frame_scheduler.

Verification
REQ-034 CE_DIV=3, run=1 for 12 cycles after reset -> ce high in cycles 3, 6, 9, 12 only; run=0 for 5 cycles mid-run -> no ce, and the phase resumes.
REQ-035 vs pulse, ack 4 cycles after update_req rises, vs falls 20 cycles later -> exactly one swap, in the cycle after vs_fall; frame_count=1; missed_frames=0.
REQ-036 No ack across 3 vs pulses -> missed_frames=2, update_req held high throughout, no swap.
REQ-037 update_ack and vs_fall asserted in the same cycle while in REQ -> swap in the next cycle, FSM in SCAN.
REQ-038 MISS_WIDTH=2 with 6 missed intervals -> missed_frames saturates at 3; frame_count wraps correctly with FRAME_WIDTH=3 after 9 vs edges (value 1).
REQ-039 rst pulsed while update_req=1 -> all outputs at reset values next cycle; a later ack pulse produces no swap.
